pe_seq_ctrl: RTL and testbench

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared PE definitions: mode encodings driven onto the PE mode input and the
// sequencer state type, used by both the PE array and its sequencer.
package pe_pkg;

    typedef enum logic [1:0] {
        MODE_DENDEN = 2'b00,
        MODE_SPADEN = 2'b01,
        MODE_SHIFT  = 2'b10,
        MODE_WAIT   = 2'b11
    } pe_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pe_seq_ctrl.sv
// Job sequencer for a PE column: CLEAR, k_len MAC cycles, ROWS SHIFT cycles, DONE.
// Optional stall-cycle counter output when PE_SEQ_CTRL_PERF_EN is defined.
module pe_seq_ctrl
    import pe_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int KW   = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic          sparse,
    input  logic          stall,
    output logic          busy,
    output logic          pe_en,
    output logic [1:0]    pe_mode,
    output logic          pe_mode_nzet,
    output logic          feed_rd,
    output logic          drain_vld,
    output logic          done
`ifdef PE_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]   perf_stall_cnt
`endif
);

    localparam int CW = maxInt(KW, $clog2(ROWS + 1));

    seq_state_t    r_state;
    logic [CW-1:0] r_count;
    logic [KW-1:0] r_kLen;
    logic          r_sparse;
    logic          w_lastStep;

    assign w_lastStep = (r_count == CW'(1));

    // The counter holds the remaining MAC or SHIFT steps of the current phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_kLen   <= '0;
            r_sparse <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_kLen   <= k_len;
                        r_sparse <= sparse;
                        r_state  <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (r_kLen == '0) begin
                        r_count <= CW'(ROWS);
                        r_state <= ST_DRAIN;
                    end else begin
                        r_count <= CW'(r_kLen);
                        r_state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (!stall) begin
                        if (w_lastStep) begin
                            r_count <= CW'(ROWS);
                            r_state <= ST_DRAIN;
                        end else begin
                            r_count <= r_count - CW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!stall) begin
                        if (w_lastStep) begin
                            r_count <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_count <= r_count - CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A stalled COMPUTE/DRAIN keeps the PE enabled but parks it in WAIT.
    always_comb begin
        busy         = (r_state != ST_IDLE);
        pe_en        = 1'b0;
        pe_mode      = MODE_WAIT;
        pe_mode_nzet = 1'b0;
        feed_rd      = 1'b0;
        drain_vld    = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_COMPUTE: begin
                pe_en = 1'b1;
                if (!stall) begin
                    pe_mode      = r_sparse ? MODE_SPADEN : MODE_DENDEN;
                    pe_mode_nzet = r_sparse;
                    feed_rd      = 1'b1;
                end
            end
            ST_DRAIN: begin
                pe_en = 1'b1;
                if (!stall) begin
                    pe_mode   = MODE_SHIFT;
                    drain_vld = 1'b1;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef PE_SEQ_CTRL_PERF_EN
    logic [31:0] r_perfCnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perfCnt <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_perfCnt <= '0;
        end else if (busy && stall && r_perfCnt != '1) begin
            r_perfCnt <= r_perfCnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perfCnt;
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: directed jobs with literal expectations
// plus randomized traffic checked every cycle against a step-queue model.
module tb_pe_seq_ctrl;

    localparam int ROWS = 4;
    localparam int KW   = 16;

    localparam int K_CLEAR = 0;
    localparam int K_MAC   = 1;
    localparam int K_SHIFT = 2;
    localparam int K_DONE  = 3;

    logic          clock;
    logic          reset;
    logic          start;
    logic [KW-1:0] k_len;
    logic          sparse;
    logic          stall;
    logic          busy;
    logic          pe_en;
    logic [1:0]    pe_mode;
    logic          pe_mode_nzet;
    logic          feed_rd;
    logic          drain_vld;
    logic          done;
`ifdef PE_SEQ_CTRL_PERF_EN
    logic [31:0]   perf_stall_cnt;
`endif

    int nVec = 0;
    int nErr = 0;

    int nFeed, nDrain, nDone, nDen, nSpa, nNzet, nWait;
    logic busyAt1;

    typedef struct {
        int kind;
        bit sp;
    } step_t;

    step_t q[$];

    pe_seq_ctrl #(.ROWS(ROWS), .KW(KW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .k_len        (k_len),
        .sparse       (sparse),
        .stall        (stall),
        .busy         (busy),
        .pe_en        (pe_en),
        .pe_mode      (pe_mode),
        .pe_mode_nzet (pe_mode_nzet),
        .feed_rd      (feed_rd),
        .drain_vld    (drain_vld),
        .done         (done)
`ifdef PE_SEQ_CTRL_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A job is the list of steps it must perform; stalled MAC/SHIFT steps stay queued.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (start === 1'b1) begin
                q.push_back('{K_CLEAR, sparse});
                for (int i = 0; i < int'(k_len); i++) q.push_back('{K_MAC, sparse});
                for (int i = 0; i < ROWS; i++) q.push_back('{K_SHIFT, sparse});
                q.push_back('{K_DONE, sparse});
            end
        end else if (!((q[0].kind == K_MAC || q[0].kind == K_SHIFT) && stall)) begin
            void'(q.pop_front());
        end
    end

    always @(negedge clock) begin
        int  kind;
        bit  sp;
        logic eBusy, eEn, eFeed, eDrain, eDone, eNzet;
        logic [1:0] eMode;
        kind   = (q.size() == 0) ? -1 : q[0].kind;
        sp     = (q.size() == 0) ? 1'b0 : q[0].sp;
        eBusy  = (kind != -1);
        eEn    = (kind == K_MAC || kind == K_SHIFT);
        eFeed  = (kind == K_MAC) && !stall;
        eDrain = (kind == K_SHIFT) && !stall;
        eDone  = (kind == K_DONE);
        eNzet  = eFeed && sp;
        eMode  = 2'b11;
        if (eFeed) eMode = sp ? 2'b01 : 2'b00;
        if (eDrain) eMode = 2'b10;
        checkOutput("m_busy", busy, eBusy);
        checkOutput("m_pe_en", pe_en, eEn);
        checkOutput("m_feed_rd", feed_rd, eFeed);
        checkOutput("m_drain_vld", drain_vld, eDrain);
        checkOutput("m_done", done, eDone);
        if (kind != K_DONE) checkOutput("m_pe_mode", pe_mode, eMode);
        if (kind == -1 || eFeed) checkOutput("m_nzet", pe_mode_nzet, eNzet);
    end

    // Runs one job from the start pulse; cycle 1 is the first cycle after the start edge.
    task automatic applyStimulus(input int k, input bit sp, input int stallAt, input int stallLen,
                                 input int extraA, input int extraB, output int lat);
        int n;
        nFeed = 0; nDrain = 0; nDone = 0; nDen = 0; nSpa = 0; nNzet = 0; nWait = 0;
        busyAt1 = 1'b0;
        lat = -1;
        k_len = k[KW-1:0];
        sparse = sp;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 1;
        while (n < 60) begin
            start = (n == extraA || n == extraB);
            stall = (n >= stallAt && n < stallAt + stallLen);
            @(negedge clock);
            if (n == 1) busyAt1 = busy;
            if (feed_rd) nFeed++;
            if (drain_vld && pe_mode == 2'b10) nDrain++;
            if (done) nDone++;
            if (pe_en && pe_mode == 2'b00) nDen++;
            if (pe_en && pe_mode == 2'b01) nSpa++;
            if (pe_mode_nzet) nNzet++;
            if (pe_en && pe_mode == 2'b11) nWait++;
            if (done && lat < 0) lat = n;
            @(posedge clock); #1;
            if (lat >= 0 && n >= lat + 3) break;
            n++;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        k_len = '0;
        sparse = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pe_mode", pe_mode, 2'b11);
        checkOutput("rst_done", done, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        $display("[TB] dense job k_len=3");
        applyStimulus(3, 1'b0, -1, 0, -1, -1, lat);
        checkOutput("dense_latency", lat, 9);
        checkOutput("dense_busy_cycle1", busyAt1, 1);
        checkOutput("dense_denden_cnt", nDen, 3);
        checkOutput("dense_feed_cnt", nFeed, 3);
        checkOutput("dense_shift_cnt", nDrain, 4);
        checkOutput("dense_done_cnt", nDone, 1);

        $display("[TB] sparse job k_len=2");
        applyStimulus(2, 1'b1, -1, 0, -1, -1, lat);
        checkOutput("sparse_latency", lat, 8);
        checkOutput("sparse_spaden_cnt", nSpa, 2);
        checkOutput("sparse_nzet_cnt", nNzet, 2);
        checkOutput("sparse_feed_cnt", nFeed, 2);

        $display("[TB] stalled job k_len=4");
        applyStimulus(4, 1'b0, 3, 2, -1, -1, lat);
        checkOutput("stall_latency", lat, 12);
        checkOutput("stall_wait_cnt", nWait, 2);
        checkOutput("stall_feed_cnt", nFeed, 4);
`ifdef PE_SEQ_CTRL_PERF_EN
        checkOutput("perf_stall_cnt", perf_stall_cnt, 2);
`endif

        $display("[TB] zero-length job");
        applyStimulus(0, 1'b0, -1, 0, -1, -1, lat);
        checkOutput("zero_latency", lat, 6);
        checkOutput("zero_feed_cnt", nFeed, 0);
        checkOutput("zero_shift_cnt", nDrain, 4);

        $display("[TB] start while busy");
        applyStimulus(3, 1'b0, -1, 0, 3, 9, lat);
        checkOutput("busystart_latency", lat, 9);
        checkOutput("busystart_done_cnt", nDone, 1);
        checkOutput("busystart_idle_after", busy, 0);

        $display("[TB] reset during DRAIN");
        k_len = 16'd3;
        sparse = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        checkOutput("pre_reset_drain", drain_vld, 1);
        reset = 1'b1;
        #1;
        checkOutput("async_busy", busy, 0);
        checkOutput("async_pe_en", pe_en, 0);
        checkOutput("async_pe_mode", pe_mode, 2'b11);
        checkOutput("async_nzet", pe_mode_nzet, 0);
        checkOutput("async_feed", feed_rd, 0);
        checkOutput("async_drain", drain_vld, 0);
        checkOutput("async_done", done, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        nDone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done) nDone++;
        end
        @(posedge clock); #1;
        checkOutput("reset_no_done", nDone, 0);
        applyStimulus(3, 1'b0, -1, 0, -1, -1, lat);
        checkOutput("post_reset_latency", lat, 9);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            k_len  = KW'($urandom_range(0, 9));
            sparse = 1'($urandom_range(0, 1));
            start  = ($urandom_range(0, 3) == 0);
            stall  = ($urandom_range(0, 3) == 0);
            @(posedge clock); #1;
        end
        start = 1'b0;
        stall = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        checkOutput("final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
